// File: rtl/snax_simbacore_cfg_sequencer.sv
// Job sequencer between the SNAX CSR manager and the SimbaCore config port.
// Buffers complete configuration sets in a small FIFO, hands them to the
// accelerator one at a time and reports busy/performance/status information.
module snax_simbacore_cfg_sequencer #(
    parameter int NumCfg       = 6,
    parameter int DataWidth    = 32,
    parameter int Depth        = 2,
    parameter int StartTimeout = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumCfg*DataWidth-1:0]     csr_cfg_i,
    input  logic                            csr_cfg_valid_i,
    output logic                            csr_cfg_ready_o,
    output logic [NumCfg*DataWidth-1:0]     acc_cfg_o,
    output logic                            acc_cfg_valid_o,
    input  logic                            acc_cfg_ready_i,
    input  logic                            acc_busy_i,
    output logic                            busy_o,
    output logic [DataWidth-1:0]            perf_cycles_o,
    output logic [DataWidth-1:0]            jobs_done_o,
    output logic [$clog2(Depth+1)-1:0]      fifo_level_o,
    output logic                            timeout_o,
    output logic                            done_o
);

    localparam int CfgWidth   = NumCfg * DataWidth;
    localparam int LevelWidth = $clog2(Depth + 1);
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int WaitWidth  = (StartTimeout > 1) ? $clog2(StartTimeout) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CfgWidth-1:0]   fifo_mem [Depth];
    logic [PtrWidth-1:0]   rd_ptr;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [LevelWidth-1:0] level;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [WaitWidth-1:0]  wait_cnt;
    logic                  job_finish;
    logic                  start_timeout;
    logic [DataWidth-1:0]  perf_cnt;
    logic [DataWidth-1:0]  jobs_cnt;
    logic                  timeout_flag;
    logic                  done_pulse;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    // A full FIFO refuses pushes even when the head leaves in the same cycle,
    // so the ready flag depends only on the registered level.
    assign fifo_empty      = (level == '0);
    assign fifo_full       = (level == LevelWidth'(Depth));
    assign csr_cfg_ready_o = !fifo_full;
    assign push            = csr_cfg_valid_i && !fifo_full;
    assign pop             = (state == ISSUE) && acc_cfg_ready_i;

    assign acc_cfg_o       = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign acc_cfg_valid_o = (state == ISSUE);
    assign busy_o          = (state != IDLE) || !fifo_empty;
    assign fifo_level_o    = level;
    assign perf_cycles_o   = perf_cnt;
    assign jobs_done_o     = jobs_cnt;
    assign timeout_o       = timeout_flag;
    assign done_o          = done_pulse;

    // Job storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= csr_cfg_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                level <= level + LevelWidth'(1);
            end else if (pop && !push) begin
                level <= level - LevelWidth'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one job at a time, always passing through IDLE between jobs.
    always_comb begin
        state_next    = state;
        job_finish    = 1'b0;
        start_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (acc_cfg_ready_i) begin
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (acc_busy_i) begin
                    state_next = RUN;
                end else if (wait_cnt == WaitWidth'(StartTimeout - 1)) begin
                    state_next    = IDLE;
                    job_finish    = 1'b1;
                    start_timeout = 1'b1;
                end
            end
            RUN: begin
                if (!acc_busy_i) begin
                    state_next = IDLE;
                    job_finish = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Cycles spent waiting for the accelerator to report busy after an accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (pop) begin
            wait_cnt <= '0;
        end else if (state == WAIT_START) begin
            wait_cnt <= wait_cnt + WaitWidth'(1);
        end
    end

    // Job statistics: saturating cycle count, wrapping job count, sticky timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt     <= '0;
            jobs_cnt     <= '0;
            timeout_flag <= 1'b0;
            done_pulse   <= 1'b0;
        end else begin
            if (pop) begin
                perf_cnt <= '0;
            end else if (((state == WAIT_START) || (state == RUN)) && (perf_cnt != '1)) begin
                perf_cnt <= perf_cnt + DataWidth'(1);
            end
            if (job_finish) begin
                jobs_cnt <= jobs_cnt + DataWidth'(1);
            end
            if (start_timeout) begin
                timeout_flag <= 1'b1;
            end
            done_pulse <= job_finish;
        end
    end

endmodule

// File: tb/tb_snax_simbacore_cfg_sequencer.sv
// Self-checking bench for snax_simbacore_cfg_sequencer. A narrow DataWidth is
// used so counter saturation and job-count wrap-around are reachable quickly.
module tb_snax_simbacore_cfg_sequencer;

    localparam int NumCfg       = 6;
    localparam int DataWidth    = 8;
    localparam int Depth        = 2;
    localparam int StartTimeout = 16;
    localparam int CfgWidth     = NumCfg * DataWidth;
    localparam int LevelWidth   = $clog2(Depth + 1);
    localparam logic [DataWidth-1:0] CountMax = '1;

    logic                  clk;
    logic                  rst_n;
    logic [CfgWidth-1:0]   csr_cfg;
    logic                  csr_cfg_valid;
    logic                  csr_cfg_ready;
    logic [CfgWidth-1:0]   acc_cfg;
    logic                  acc_cfg_valid;
    logic                  acc_cfg_ready;
    logic                  acc_busy;
    logic                  busy;
    logic [DataWidth-1:0]  perf_cycles;
    logic [DataWidth-1:0]  jobs_done;
    logic [LevelWidth-1:0] fifo_level;
    logic                  timeout;
    logic                  done;

    snax_simbacore_cfg_sequencer #(
        .NumCfg       (NumCfg),
        .DataWidth    (DataWidth),
        .Depth        (Depth),
        .StartTimeout (StartTimeout)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .csr_cfg_i       (csr_cfg),
        .csr_cfg_valid_i (csr_cfg_valid),
        .csr_cfg_ready_o (csr_cfg_ready),
        .acc_cfg_o       (acc_cfg),
        .acc_cfg_valid_o (acc_cfg_valid),
        .acc_cfg_ready_i (acc_cfg_ready),
        .acc_busy_i      (acc_busy),
        .busy_o          (busy),
        .perf_cycles_o   (perf_cycles),
        .jobs_done_o     (jobs_done),
        .fifo_level_o    (fifo_level),
        .timeout_o       (timeout),
        .done_o          (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Reference model: a queue of pending jobs plus the lifecycle of the job
    // currently handed to the accelerator.
    logic [CfgWidth-1:0]  model_queue [$];
    bit                   m_offering;
    bit                   m_active;
    bit                   m_started;
    bit                   m_done;
    bit                   m_timeout;
    int                   m_wait;
    logic [DataWidth-1:0] m_perf;
    logic [DataWidth-1:0] m_jobs;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        model_queue.delete();
        m_offering = 0;
        m_active   = 0;
        m_started  = 0;
        m_done     = 0;
        m_timeout  = 0;
        m_wait     = 0;
        m_perf     = '0;
        m_jobs     = '0;
    endtask

    task automatic model_finish_job();
        m_active = 0;
        m_done   = 1;
        m_jobs   = m_jobs + 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit                  do_push;
        bit                  had_jobs;
        logic [CfgWidth-1:0] pushed;
        do_push  = csr_cfg_valid && (model_queue.size() < Depth);
        had_jobs = (model_queue.size() > 0);
        pushed   = csr_cfg;
        m_done   = 0;
        if (m_offering) begin
            if (acc_cfg_ready) begin
                void'(model_queue.pop_front());
                m_offering = 0;
                m_active   = 1;
                m_started  = 0;
                m_wait     = 0;
                m_perf     = '0;
            end
        end else if (m_active) begin
            if (m_perf != CountMax) m_perf = m_perf + 1'b1;
            if (!m_started) begin
                if (acc_busy) begin
                    m_started = 1;
                end else if (m_wait == StartTimeout - 1) begin
                    m_timeout = 1;
                    model_finish_job();
                end else begin
                    m_wait++;
                end
            end else if (!acc_busy) begin
                model_finish_job();
            end
        end else if (had_jobs) begin
            m_offering = 1;
        end
        if (do_push) model_queue.push_back(pushed);
    endtask

    task automatic check_outputs();
        logic [CfgWidth-1:0] head;
        head = (model_queue.size() > 0) ? model_queue[0] : '0;
        chk("csr_cfg_ready", csr_cfg_ready, 64'(model_queue.size() < Depth));
        chk("fifo_level", fifo_level, 64'(model_queue.size()));
        chk("acc_cfg_valid", acc_cfg_valid, 64'(m_offering));
        chk("acc_cfg", acc_cfg, 64'(head));
        chk("busy", busy, 64'(m_offering || m_active || (model_queue.size() > 0)));
        chk("perf_cycles", perf_cycles, 64'(m_perf));
        chk("jobs_done", jobs_done, 64'(m_jobs));
        chk("timeout", timeout, 64'(m_timeout));
        chk("done", done, 64'(m_done));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, csr_cfg_ready, 1);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_valid"}, acc_cfg_valid, 0);
        chk({tag, "_acc_cfg"}, acc_cfg, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_perf"}, perf_cycles, 0);
        chk({tag, "_jobs"}, jobs_done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // One clock cycle: check at the falling edge, drive inputs, step model.
    task automatic applyStimulus(input logic v, input logic [CfgWidth-1:0] cfg,
                                 input logic rdy, input logic bsy);
        check_outputs();
        csr_cfg_valid = v;
        csr_cfg       = cfg;
        acc_cfg_ready = rdy;
        acc_busy      = bsy;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [CfgWidth-1:0] make_cfg(input int mode, input int seq_len);
        logic [CfgWidth-1:0] cfg;
        cfg = '0;
        cfg[0 +: DataWidth]         = DataWidth'(mode);
        cfg[DataWidth +: DataWidth] = DataWidth'(seq_len);
        return cfg;
    endfunction

    task automatic random_cycle(input int push_pct, input int ready_pct, input int busy_pct);
        logic [CfgWidth-1:0] cfg;
        for (int w = 0; w < NumCfg; w++) cfg[w*DataWidth +: DataWidth] = DataWidth'($urandom);
        applyStimulus($urandom_range(99) < push_pct, cfg,
                      $urandom_range(99) < ready_pct, $urandom_range(99) < busy_pct);
    endtask

    // Directed scenarios followed by randomized traffic, all model-checked.
    initial begin
        logic [CfgWidth-1:0] cfg_b;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        csr_cfg       = '0;
        csr_cfg_valid = 1'b0;
        acc_cfg_ready = 1'b0;
        acc_busy      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Single job: accepted on the first offer, accelerator busy for 10 cycles.
        applyStimulus(1, make_cfg(1, 64), 0, 0);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 1, 0);
        repeat (10) applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        chk("single_done", done, 1);
        chk("single_perf", perf_cycles, 11);
        chk("single_jobs", jobs_done, 1);
        applyStimulus(0, '0, 0, 0);
        chk("single_idle_busy", busy, 0);

        // Backpressure: the offer must hold still while the accelerator stalls.
        cfg_b = make_cfg(2, 16);
        applyStimulus(1, cfg_b, 0, 0);
        applyStimulus(0, '0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", acc_cfg_valid, 1);
            chk("bp_data", acc_cfg, 64'(cfg_b));
            applyStimulus(0, '0, 0, 0);
        end
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        chk("bp_jobs", jobs_done, 2);

        // Queue full: three pushes while a job runs; the third must be refused.
        applyStimulus(1, make_cfg(1, 4), 0, 0);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 1, 1);
        applyStimulus(1, make_cfg(1, 8), 0, 1);
        applyStimulus(1, make_cfg(1, 16), 0, 1);
        chk("full_ready", csr_cfg_ready, 0);
        chk("full_level", fifo_level, 2);
        for (int i = 0; i < 40; i++) applyStimulus(1, make_cfg(1, 32), 1, $urandom_range(1));

        // Mixed random traffic; long enough for the job counter to wrap.
        for (int i = 0; i < 4000; i++) random_cycle(50, 60, 70);

        // Accelerator never starts: every job ends by timeout.
        for (int i = 0; i < 300; i++) random_cycle(100, 100, 0);
        chk("timeout_sticky", timeout, 1);

        // Accelerator stays busy long enough to saturate the cycle counter.
        for (int i = 0; i < 300; i++) random_cycle(100, 100, 100);
        chk("perf_saturated", perf_cycles, 64'(CountMax));
        chk("queued_before_reset", fifo_level, 2);

        // Asynchronous reset mid-run with jobs still queued.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) random_cycle(50, 60, 70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
